// File: rtl/act_pingpong_buffer.sv
// rtl/act_pingpong_buffer.sv - double-banked activation buffer between the ReLU stage and the systolic array
// One bank streams the current feature map while the other collects that layer's results; banks swap on completion.
module act_pingpong_buffer #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DIM_W      = 4
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               grid_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] grid_id,
  input  logic                               load_layer_info,
  input  logic [DIM_W-1:0]                   ifmap_h,
  input  logic [DIM_W-1:0]                   ifmap_w,
  input  logic [DIM_W-1:0]                   out_h,
  input  logic [DIM_W-1:0]                   out_w,
  input  logic                               is_first_layer,
  input  logic                               is_last_layer,
  input  logic                               op_sel,
  input  logic                               flatten,
  input  logic                               send_sd,
  input  logic                               sd_ready,
  output logic                               sd_sign_en,
  output logic                               sd_ov,
  output logic [WIDTH*DATA_WIDTH-1:0]        sd_od,
  input  logic                               res_conv_iv,
  input  logic [DATA_WIDTH-1:0]              res_conv_id,
  input  logic                               res_mul_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] res_mul_id,
  output logic                               layer_done,
  output logic                               dnn_ov,
  output logic [DATA_WIDTH-1:0]              dnn_od,
  output logic                               busy
);

  localparam int NE = HEIGHT * WIDTH;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW = $clog2(NE + 1);
  localparam int XW = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_COLLECT} state_t;

  state_t                state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  cfg_ok_q, cfg_ok_d;
  logic                  sign_en_q, sign_en_d;
  logic                  last_q, last_d;
  logic                  op_q, op_d;
  logic                  flat_q, flat_d;
  logic [DIM_W-1:0]      ih_q, ih_d, iw_q, iw_d, oh_q, oh_d, ow_q, ow_d;
  logic [DIM_W-1:0]      wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [CW-1:0]         beat_q, beat_d, wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] first_q, first_d, dnn_od_q, dnn_od_d;
  logic                  layer_done_q, layer_done_d, dnn_ov_q, dnn_ov_d;

  logic [DATA_WIDTH-1:0] bank_q [2][NE];

  // Dimensions larger than the physical bank are clamped to it.
  logic [DIM_W-1:0] eff_ih, eff_iw, eff_oh, eff_ow, eff_iw_nz;
  assign eff_ih    = (ih_q > DIM_W'(HEIGHT)) ? DIM_W'(HEIGHT) : ih_q;
  assign eff_iw    = (iw_q > DIM_W'(WIDTH))  ? DIM_W'(WIDTH)  : iw_q;
  assign eff_oh    = (oh_q > DIM_W'(HEIGHT)) ? DIM_W'(HEIGHT) : oh_q;
  assign eff_ow    = (ow_q > DIM_W'(WIDTH))  ? DIM_W'(WIDTH)  : ow_q;
  assign eff_iw_nz = (eff_iw == '0) ? DIM_W'(1) : eff_iw;

  logic [XW-1:0] n_flat, n_beats, n_res;
  assign n_flat  = XW'(eff_ih) * XW'(eff_iw);
  assign n_beats = flat_q ? (n_flat + XW'(WIDTH - 1)) / XW'(WIDTH) : XW'(eff_ih);
  assign n_res   = XW'(eff_oh) * XW'(eff_ow);

  logic st_idle, st_stream, capture;
  logic grid_load, cfg_load, start;
  logic mul_hit, conv_hit, conv_last, done, beat_fire, last_beat;
  logic wr_bank, clr_bank;
  logic [EW-1:0] conv_addr;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_stream = (state_q == ST_STREAM);
  assign capture   = (state_q == ST_STREAM) || (state_q == ST_COLLECT);
  assign grid_load = st_idle && grid_iv;
  assign cfg_load  = st_idle && load_layer_info;
  assign start     = st_idle && send_sd && cfg_ok_q;
  assign mul_hit   = capture && op_q && res_mul_iv;
  assign conv_hit  = capture && !op_q && res_conv_iv && (XW'(wr_cnt_q) < n_res);
  assign conv_last = conv_hit && (XW'(wr_cnt_q) + XW'(1) == n_res);
  assign done      = mul_hit || conv_last;
  assign beat_fire = st_stream && sd_ready;
  assign last_beat = (XW'(beat_q) + XW'(1) == n_beats);
  assign wr_bank   = ~rd_bank_q;
  // A board load in the same cycle as a start makes bank1 the write bank.
  assign clr_bank  = grid_load ? 1'b1 : ~rd_bank_q;
  assign conv_addr = EW'(XW'(wr_row_q) * XW'(WIDTH) + XW'(wr_col_q));

  // Streamed word for the current beat, raster rows or flattened map.
  logic [WIDTH*DATA_WIDTH-1:0] word;
  logic [XW-1:0]               fidx, frow, fcol;
  logic [EW-1:0]               eidx;

  always_comb begin
    word = '0;
    fidx = '0;
    frow = '0;
    fcol = '0;
    eidx = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (flat_q) begin
        fidx = XW'(beat_q) * XW'(WIDTH) + XW'(c);
        if (fidx < n_flat) begin
          frow = fidx / XW'(eff_iw_nz);
          fcol = fidx % XW'(eff_iw_nz);
          eidx = EW'(frow * XW'(WIDTH) + fcol);
          word[c*DATA_WIDTH +: DATA_WIDTH] = bank_q[rd_bank_q][eidx];
        end
      end else if (XW'(c) < XW'(eff_iw)) begin
        eidx = EW'(XW'(beat_q) * XW'(WIDTH) + XW'(c));
        word[c*DATA_WIDTH +: DATA_WIDTH] = bank_q[rd_bank_q][eidx];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    cfg_ok_d     = cfg_ok_q;
    sign_en_d    = sign_en_q;
    last_d       = last_q;
    op_d         = op_q;
    flat_d       = flat_q;
    ih_d         = ih_q;
    iw_d         = iw_q;
    oh_d         = oh_q;
    ow_d         = ow_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    beat_d       = beat_q;
    wr_cnt_d     = wr_cnt_q;
    first_d      = first_q;
    dnn_od_d     = dnn_od_q;
    layer_done_d = 1'b0;
    dnn_ov_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grid_load) rd_bank_d = 1'b0;
        if (cfg_load) begin
          ih_d      = ifmap_h;
          iw_d      = ifmap_w;
          oh_d      = out_h;
          ow_d      = out_w;
          sign_en_d = ~is_first_layer;
          last_d    = is_last_layer;
          op_d      = op_sel;
          flat_d    = flatten;
          cfg_ok_d  = 1'b1;
        end
        if (start) begin
          beat_d   = '0;
          wr_cnt_d = '0;
          wr_row_d = '0;
          wr_col_d = '0;
          state_d  = (n_beats == '0) ? ST_COLLECT : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat_fire) begin
          if (last_beat) state_d = ST_COLLECT;
          else           beat_d  = beat_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (conv_hit) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      if (wr_cnt_q == '0) first_d = res_conv_id;
      if (wr_col_q + DIM_W'(1) == eff_ow) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + DIM_W'(1);
      end else begin
        wr_col_d = wr_col_q + DIM_W'(1);
      end
    end

    // Completion wins over any streaming progress in the same cycle.
    if (done) begin
      state_d      = ST_IDLE;
      rd_bank_d    = ~rd_bank_q;
      cfg_ok_d     = 1'b0;
      layer_done_d = 1'b1;
      if (last_q) begin
        dnn_ov_d = 1'b1;
        if (op_q)                 dnn_od_d = res_mul_id[DATA_WIDTH-1:0];
        else if (wr_cnt_q == '0)  dnn_od_d = res_conv_id;
        else                      dnn_od_d = first_q;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      rd_bank_q    <= 1'b0;
      cfg_ok_q     <= 1'b0;
      sign_en_q    <= 1'b0;
      last_q       <= 1'b0;
      op_q         <= 1'b0;
      flat_q       <= 1'b0;
      ih_q         <= '0;
      iw_q         <= '0;
      oh_q         <= '0;
      ow_q         <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      beat_q       <= '0;
      wr_cnt_q     <= '0;
      first_q      <= '0;
      dnn_od_q     <= '0;
      layer_done_q <= 1'b0;
      dnn_ov_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      cfg_ok_q     <= cfg_ok_d;
      sign_en_q    <= sign_en_d;
      last_q       <= last_d;
      op_q         <= op_d;
      flat_q       <= flat_d;
      ih_q         <= ih_d;
      iw_q         <= iw_d;
      oh_q         <= oh_d;
      ow_q         <= ow_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      beat_q       <= beat_d;
      wr_cnt_q     <= wr_cnt_d;
      first_q      <= first_d;
      dnn_od_q     <= dnn_od_d;
      layer_done_q <= layer_done_d;
      dnn_ov_q     <= dnn_ov_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NE; i++)
          bank_q[b][i] <= '0;
    end else begin
      if (grid_load)
        for (int i = 0; i < NE; i++)
          bank_q[0][i] <= grid_id[i*DATA_WIDTH +: DATA_WIDTH];
      if (start)
        for (int i = 0; i < NE; i++)
          bank_q[clr_bank][i] <= '0;
      if (mul_hit)
        for (int i = 0; i < NE; i++)
          bank_q[wr_bank][i] <= res_mul_id[i*DATA_WIDTH +: DATA_WIDTH];
      if (conv_hit)
        bank_q[wr_bank][conv_addr] <= res_conv_id;
    end
  end

  assign sd_ov      = st_stream;
  assign sd_od      = st_stream ? word : '0;
  assign sd_sign_en = sign_en_q;
  assign layer_done = layer_done_q;
  assign dnn_ov     = dnn_ov_q;
  assign dnn_od     = dnn_od_q;
  assign busy       = !st_idle;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// tb/tb_act_pingpong_buffer.sv - scoreboard bench for act_pingpong_buffer
module tb_act_pingpong_buffer;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int DW   = 8;
  localparam int DIMW = 4;
  localparam int MW   = H * W * DW;
  localparam int WW   = W * DW;

  logic            clk = 1'b0;
  logic            nrst;
  logic            grid_iv, load_layer_info, send_sd, sd_ready;
  logic [MW-1:0]   grid_id, res_mul_id;
  logic [DIMW-1:0] ifmap_h, ifmap_w, out_h, out_w;
  logic            is_first_layer, is_last_layer, op_sel, flatten;
  logic            res_conv_iv, res_mul_iv;
  logic [DW-1:0]   res_conv_id;
  logic            sd_sign_en, sd_ov, layer_done, dnn_ov, busy;
  logic [WW-1:0]   sd_od;
  logic [DW-1:0]   dnn_od;

  always #5 clk = ~clk;

  act_pingpong_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .DIM_W(DIMW)) dut (
    .clk(clk), .nrst(nrst), .grid_iv(grid_iv), .grid_id(grid_id),
    .load_layer_info(load_layer_info), .ifmap_h(ifmap_h), .ifmap_w(ifmap_w),
    .out_h(out_h), .out_w(out_w), .is_first_layer(is_first_layer),
    .is_last_layer(is_last_layer), .op_sel(op_sel), .flatten(flatten),
    .send_sd(send_sd), .sd_ready(sd_ready), .sd_sign_en(sd_sign_en),
    .sd_ov(sd_ov), .sd_od(sd_od), .res_conv_iv(res_conv_iv),
    .res_conv_id(res_conv_id), .res_mul_iv(res_mul_iv), .res_mul_id(res_mul_id),
    .layer_done(layer_done), .dnn_ov(dnn_ov), .dnn_od(dnn_od), .busy(busy)
  );

  logic [WW-1:0] exp_beats[$];
  logic [DW:0]   exp_done[$];
  logic [DW:0]   exp_e;
  logic          exp_sign = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, ahead of the edge that transfers.
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (sd_ov) begin
        chk("sd_sign_en", WW'(sd_sign_en), WW'(exp_sign));
        if (exp_beats.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got %h, expected no beat", sd_od);
        end else if (sd_ready) begin
          chk("beat", sd_od, exp_beats.pop_front());
        end else begin
          chk("beat_held", sd_od, exp_beats[0]);
        end
      end
      if (layer_done) begin
        if (exp_done.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_layer_done: got 1, expected 0");
        end else begin
          exp_e = exp_done.pop_front();
          chk("dnn_ov", WW'(dnn_ov), WW'(exp_e[DW]));
          if (exp_e[DW]) chk("dnn_od", WW'(dnn_od), WW'(exp_e[DW-1:0]));
        end
      end else if (dnn_ov) begin
        n_cmp++; n_err++;
        $display("FAIL dnn_ov_alone: got 1, expected 0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c,
                                        input logic [DW-1:0] v);
    m[(r*W+c)*DW +: DW] = v;
    return m;
  endfunction

  task automatic cfg(input int h, input int w, input int oh, input int ow,
                     input logic first, input logic last, input logic op, input logic fl);
    ifmap_h = DIMW'(h); ifmap_w = DIMW'(w); out_h = DIMW'(oh); out_w = DIMW'(ow);
    is_first_layer = first; is_last_layer = last; op_sel = op; flatten = fl;
    load_layer_info = 1'b1;
    tick();
    load_layer_info = 1'b0;
    exp_sign = ~first;
  endtask

  task automatic run_stream(input string nm, input int n_exp, input bit stall);
    int cnt;
    int i;
    logic hs;
    cnt = 0;
    sd_ready = 1'b1;
    send_sd  = 1'b1;
    tick();
    send_sd  = 1'b0;
    chk({nm, "_sd_ov_rise"}, WW'(sd_ov), WW'(1));
    for (i = 0; i < 200; i++) begin
      if (!sd_ov) break;
      sd_ready = stall ? ((i % 3) == 0) : 1'b1;
      hs = sd_ready;
      tick();
      if (hs) cnt++;
    end
    sd_ready = 1'b0;
    if (i == 200) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got sd_ov still 1, expected 0", nm);
    end
    chk({nm, "_beats"}, WW'(cnt), WW'(n_exp));
    chk({nm, "_queue_drained"}, WW'(exp_beats.size()), WW'(0));
    chk({nm, "_busy_collect"}, WW'(busy), WW'(1));
  endtask

  task automatic push_map6();
    logic [WW-1:0] wd;
    for (int r = 0; r < 6; r++) begin
      wd = '0;
      for (int c = 0; c < 6; c++) wd[c*DW +: DW] = DW'(r*6 + c + 1);
      exp_beats.push_back(wd);
    end
  endtask

  task automatic finish_mul(input string nm, input logic [MW-1:0] m, input logic last,
                            input logic [DW-1:0] od);
    exp_done.push_back({last, od});
    res_mul_id = m;
    res_mul_iv = 1'b1;
    tick();
    res_mul_iv = 1'b0;
    chk({nm, "_layer_done"}, WW'(layer_done), WW'(1));
    tick();
    chk({nm, "_done_pulse_end"}, WW'(layer_done), WW'(0));
    chk({nm, "_idle"}, WW'(busy), WW'(0));
  endtask

  logic [MW-1:0] board, m;
  logic [WW-1:0] wd;
  logic [DW-1:0] row0 [8];

  initial begin
    row0 = '{8'h44, 8'h48, 8'h50, 8'h42, 8'h41, 8'h50, 8'h48, 8'h44};
    board = '0;
    for (int c = 0; c < 8; c++) begin
      board = put(board, 0, c, row0[c]);
      board = put(board, 1, c, DW'(8'h31 + c));
      for (int r = 2; r < 6; r++) board = put(board, r, c, 8'h7F);
      board = put(board, 6, c, DW'(8'h61 + c));
      board = put(board, 7, c, row0[c] - 8'h20);
    end

    nrst = 1'b0; grid_iv = 1'b0; grid_id = '0; load_layer_info = 1'b0;
    ifmap_h = '0; ifmap_w = '0; out_h = '0; out_w = '0;
    is_first_layer = 1'b0; is_last_layer = 1'b0; op_sel = 1'b0; flatten = 1'b0;
    send_sd = 1'b0; sd_ready = 1'b0; res_conv_iv = 1'b0; res_conv_id = '0;
    res_mul_iv = 1'b0; res_mul_id = '0;
    tick(); tick();
    chk("rst_sd_ov", WW'(sd_ov), WW'(0));
    chk("rst_sd_od", sd_od, WW'(0));
    chk("rst_sign_en", WW'(sd_sign_en), WW'(0));
    chk("rst_layer_done", WW'(layer_done), WW'(0));
    chk("rst_dnn", WW'({dnn_ov, dnn_od}), WW'(0));
    chk("rst_busy", WW'(busy), WW'(0));
    nrst = 1'b1;
    tick();

    // Layer 1: board, 8x8 conv, first layer.
    grid_id = board; grid_iv = 1'b1; tick(); grid_iv = 1'b0;
    cfg(8, 8, 6, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) exp_beats.push_back(board[r*WW +: WW]);
    run_stream("l1", 8, 1'b0);
    exp_done.push_back({1'b0, 8'h00});
    res_conv_iv = 1'b1;
    for (int v = 1; v <= 36; v++) begin
      if (v == 36) chk("l1_no_early_done", WW'(layer_done), WW'(0));
      res_conv_id = DW'(v);
      tick();
    end
    res_conv_iv = 1'b0;
    chk("l1_layer_done", WW'(layer_done), WW'(1));
    tick();
    chk("l1_done_pulse_end", WW'(layer_done), WW'(0));
    chk("l1_idle", WW'(busy), WW'(0));

    // Layer 2: 6x6 conv results, mul op; result matrix has junk outside 6x6.
    cfg(6, 6, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_map6();
    run_stream("l2", 6, 1'b0);
    m = '1 & {(MW/8){8'hEE}};
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) m = put(m, r, c, DW'(r*6 + c + 1));
    finish_mul("l2", m, 1'b0, 8'h00);

    // Layer 3: same map with ready stalls.
    cfg(6, 6, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_map6();
    run_stream("l3_stall", 6, 1'b1);
    m = {(MW/8){8'hAA}};
    for (int i = 0; i < 8; i++) m = put(m, i / 4, i % 4, DW'(i + 1));
    finish_mul("l3", m, 1'b0, 8'h00);

    // Layer 4: flatten 2x4 into a single beat.
    cfg(2, 4, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    wd = '0;
    for (int c = 0; c < 8; c++) wd[c*DW +: DW] = DW'(c + 1);
    exp_beats.push_back(wd);
    run_stream("l4_flat", 1, 1'b0);
    m = {(MW/8){8'h55}};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) m = put(m, r, c, DW'(r*3 + c + 1));
    finish_mul("l4", m, 1'b0, 8'h00);

    // Layer 5: flatten 3x3 into two beats, last layer.
    cfg(3, 3, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_beats.push_back(wd);
    exp_beats.push_back(WW'(9));
    run_stream("l5_flat", 2, 1'b0);
    m = put({(MW/8){8'h11}}, 0, 0, 8'hF1);
    res_conv_iv = 1'b1; res_conv_id = 8'h33;
    exp_done.push_back({1'b1, 8'hF1});
    res_mul_id = m; res_mul_iv = 1'b1;
    tick();
    res_mul_iv = 1'b0; res_conv_iv = 1'b0;
    chk("l5_layer_done", WW'(layer_done), WW'(1));
    chk("l5_dnn_ov", WW'(dnn_ov), WW'(1));
    chk("l5_dnn_od", WW'(dnn_od), WW'(8'hF1));
    tick();
    chk("l5_dnn_ov_end", WW'(dnn_ov), WW'(0));

    // send_sd without a loaded config is ignored.
    send_sd = 1'b1; tick(); send_sd = 1'b0;
    chk("nocfg_busy", WW'(busy), WW'(0));

    // Reset in the middle of a stream.
    grid_id = board; grid_iv = 1'b1; tick(); grid_iv = 1'b0;
    cfg(8, 8, 6, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) exp_beats.push_back(board[r*WW +: WW]);
    sd_ready = 1'b1; send_sd = 1'b1; tick(); send_sd = 1'b0;
    tick(); tick(); tick();
    sd_ready = 1'b0;
    nrst = 1'b0;
    #1;
    chk("mid_rst_sd_ov", WW'(sd_ov), WW'(0));
    chk("mid_rst_busy", WW'(busy), WW'(0));
    chk("mid_rst_layer_done", WW'(layer_done), WW'(0));
    chk("mid_rst_queue", WW'(exp_beats.size()), WW'(0));
    @(posedge clk); #1;
    nrst = 1'b1;
    tick();
    cfg(8, 8, 6, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) exp_beats.push_back('0);
    run_stream("post_rst_zero", 8, 1'b0);
    tick(); tick();
    chk("done_queue_drained", WW'(exp_done.size()), WW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
